// File: rtl/new_step1_if.sv
// new_step1_if: operand-read, write-back and ALU control bus of the execute-stage slice
interface new_step1_if;
  logic [3:0] rdAddr;
  logic [3:0] rs0Addr;
  logic [3:0] rs1Addr;
  logic writeEnable;
  logic [15:0] dataWrite;
  logic [15:0] immediate;
  logic [15:0] PC;
  logic ALUSrcA;
  logic ALUSrcB;
  logic [2:0] ALUOp;
  logic signed [15:0] A;
  logic signed [15:0] B;
  logic signed [15:0] ALUOut;
  modport master (
    output rdAddr, rs0Addr, rs1Addr, writeEnable, dataWrite, immediate, PC,
    output ALUSrcA, ALUSrcB, ALUOp,
    input A, B, ALUOut
  );
  modport slave (
    input rdAddr, rs0Addr, rs1Addr, writeEnable, dataWrite, immediate, PC,
    input ALUSrcA, ALUSrcB, ALUOp,
    output A, B, ALUOut
  );
endinterface

// File: rtl/new_step1.sv
// new_step1: register file, A/B operand registers and registered 16-bit ALU
module new_step1 #(
  parameter logic [15:0] INIT_R4 = 16'd5,
  parameter logic [15:0] INIT_R5 = 16'd2
) (
  input logic CLK,
  input logic reset,
  new_step1_if.slave bus
);
  logic [15:0] rf [16];
  logic [15:0] in1;
  logic [15:0] in2;
  logic [15:0] res;
  logic [3:0] sh;
  assign rf[0] = '0;
  // Register contents are not reset; only power-up values apply.
  for (genvar i = 1; i < 16; i++) begin : g_reg
    logic [15:0] q = i == 4 ? INIT_R4 : i == 5 ? INIT_R5 : 16'd0;
    always_ff @(posedge CLK)
      if (bus.writeEnable && bus.rdAddr == 4'(i)) q <= bus.dataWrite;
    assign rf[i] = q;
  end
  assign in1 = bus.ALUSrcA ? bus.A : bus.PC;
  assign in2 = bus.ALUSrcB ? bus.immediate : bus.B;
  assign sh = in2[3:0];
  always_comb begin
    res = bus.ALUOp == 3'd0 ? in1 + in2 :
          bus.ALUOp == 3'd1 ? in1 - in2 :
          bus.ALUOp == 3'd2 ? in1 & in2 :
          bus.ALUOp == 3'd3 ? in1 | in2 :
          bus.ALUOp == 3'd4 ? in1 ^ in2 :
          bus.ALUOp == 3'd5 ? in1 << sh :
          bus.ALUOp == 3'd6 ? in1 >> sh :
          16'($signed(in1) >>> sh);
  end
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      bus.A <= '0;
      bus.B <= '0;
      bus.ALUOut <= '0;
    end else begin
      bus.A <= rf[bus.rs0Addr];
      bus.B <= rf[bus.rs1Addr];
      bus.ALUOut <= res;
    end
endmodule

// File: tb/tb_new_step1.sv
// tb_new_step1: directed vectors with hand-computed results for new_step1
module tb_new_step1;
  logic clk = 0;
  logic reset = 0;
  int errors = 0;
  int checks = 0;
  new_step1_if bus ();
  new_step1 dut (.CLK(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic aluop(input string tag, input logic [2:0] op, input logic [15:0] exp);
    bus.ALUOp = op;
    step(1);
    check(tag, bus.ALUOut, exp);
  endtask
  initial begin
    bus.rdAddr = 0; bus.rs0Addr = 4; bus.rs1Addr = 5; bus.writeEnable = 0;
    bus.dataWrite = 0; bus.immediate = 0; bus.PC = 16'd22;
    bus.ALUSrcA = 1; bus.ALUSrcB = 0; bus.ALUOp = 0;
    reset = 1;
    step(2);
    check("rst_A", bus.A, 0);
    check("rst_B", bus.B, 0);
    check("rst_out", bus.ALUOut, 0);
    reset = 0;
    step(1);
    check("A_r4", bus.A, 16'd5);
    check("B_r5", bus.B, 16'd2);
    step(1);
    check("add_AB", bus.ALUOut, 16'd7);
    #3 reset = 1;
    #1;
    check("async_A", bus.A, 0);
    check("async_B", bus.B, 0);
    check("async_out", bus.ALUOut, 0);
    step(1);
    reset = 0;
    bus.ALUSrcB = 1; bus.immediate = 16'd10;
    step(1);
    check("refill1", bus.ALUOut, 16'd10);
    step(1);
    check("add_imm", bus.ALUOut, 16'd15);
    check("r4_kept", bus.A, 16'd5);
    check("r5_kept", bus.B, 16'd2);
    bus.immediate = 16'hFFFF;
    aluop("add_wrap", 0, 16'd4);
    bus.ALUSrcA = 0; bus.ALUSrcB = 0;
    aluop("add_pc", 0, 16'd24);
    bus.ALUSrcA = 1;
    aluop("sub", 1, 16'd3);
    aluop("and", 2, 16'd0);
    aluop("or", 3, 16'd7);
    aluop("xor", 4, 16'd7);
    aluop("sll", 5, 16'd20);
    aluop("srl", 6, 16'd1);
    bus.ALUSrcB = 1; bus.immediate = 16'd10;
    aluop("sub_neg", 1, 16'hFFFB);
    bus.rdAddr = 7; bus.writeEnable = 1; bus.dataWrite = 16'h8000;
    step(1);
    bus.writeEnable = 0; bus.rs0Addr = 7;
    step(1);
    check("A_r7", bus.A, 16'h8000);
    bus.immediate = 16'h0011;
    aluop("sra", 7, 16'hC000);
    aluop("srl_mask", 6, 16'h4000);
    aluop("sll_mask", 5, 16'h0000);
    bus.rdAddr = 6; bus.writeEnable = 1; bus.dataWrite = 16'd9; bus.rs0Addr = 6;
    step(1);
    check("no_bypass", bus.A, 0);
    bus.writeEnable = 0;
    step(1);
    check("A_r6", bus.A, 16'd9);
    bus.rdAddr = 0; bus.writeEnable = 1; bus.dataWrite = 16'h1234; bus.rs0Addr = 0;
    step(1);
    bus.writeEnable = 0;
    step(1);
    check("r0_zero", bus.A, 0);
    reset = 1;
    bus.rdAddr = 8; bus.writeEnable = 1; bus.dataWrite = 16'd77;
    step(1);
    check("rst_hold", bus.ALUOut, 0);
    reset = 0; bus.writeEnable = 0; bus.rs1Addr = 8;
    step(1);
    check("wr_in_rst", bus.B, 16'd77);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
